seq_mul: RTL and testbench
==========================

Name: seq_mul

Overview:
- Iterative shift-add integer multiplier; the companion to the sequential divider in the execute-stage multi-cycle unit.
- Serves MULT/MULTU: takes two WIDTH-bit operands on a start pulse and produces the 2*WIDTH-bit product as hi/lo.
- busy stalls the pipeline; the hi/lo registers are loaded when the operation completes.

Parameters:
- WIDTH, 32, operand width in bits; must be even and at least 4.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; operands and sign_mode are sampled on this edge
- sign_mode  in  1  1 = signed (MULT), 0 = unsigned (MULTU)
- multiplicand  in  WIDTH  operand A
- multiplier  in  WIDTH  operand B
- hi  out  WIDTH  upper half of the product (registered)
- lo  out  WIDTH  lower half of the product (registered)
- busy  out  1  high while an iteration is in progress
- done  out  1  one-cycle pulse when hi/lo are updated

Behaviour:
- Reset (reset=0, asynchronous): busy=0, done=0, hi=0, lo=0; counter, accumulator and sign flag cleared. Any operation in flight is discarded and no done is produced.
- States: IDLE, RUN. Derive the state from busy, or encode it explicitly.
- Start, from any state:
  - Latch neg = sign_mode & (A[W-1] ^ B[W-1]).
  - Load mcand = |A| and mplr = |B|. Magnitudes are taken only when sign_mode=1; otherwise the raw value is used.
  - Clear acc (WIDTH+1 bits), set cnt=0, busy=1, done=0.
  - start while busy aborts the current operation and restarts with the new operands. The old result is never written.
- RUN, each cycle:
  - sum = acc + (mplr[0] ? mcand : 0), computed at WIDTH+1 bits.
  - {acc, mplr} <= {sum, mplr} >> 1.
  - cnt <= cnt + 1.
- Completion, on the edge where cnt reaches WIDTH-1:
  - Compute P = {final acc, final mplr} (2*WIDTH bits).
  - {hi, lo} <= neg ? (~P + 1) : P.
  - busy <= 0, done <= 1 for exactly one cycle.
- Latency: busy is high for exactly WIDTH cycles after the start edge. hi/lo and done update on the WIDTH-th rising edge after the start edge.
- hi/lo hold the previous result throughout RUN, and hold until the next completion.
- Boundary conditions:
  - -2^(W-1) magnitude is 2^(W-1), which fits in unsigned WIDTH bits, so no overflow.
  - Zero operand: the product is 0 regardless of neg, since the negation of 0 is 0.
  - The final accumulator carry bit is always 0 and is dropped.
  - start and reset asserted together: reset wins.
- No divide-style remainder correction is required; each step is exact.

Optional Feature:
- Macro: SEQ_MUL_RADIX4_EN.
- Defined:
  - Consume 2 multiplier bits per cycle: sum = acc + mplr[1:0]*mcand, acc widened to WIDTH+2 bits, shift right by 2.
  - busy lasts WIDTH/2 cycles; completion occurs when cnt reaches WIDTH/2-1.
- Undefined: radix-2, WIDTH cycles as above.
- Results are identical in both builds.

Decomposition:
- Package seq_mul_pkg holds:
  - localparam CNT_W = $clog2(WIDTH).
  - Iteration-count constants for radix-2 and radix-4.
  - The sign_mode encoding constants SIGNED/UNSIGNED.
- One sub-module: twos_abs (WIDTH-bit conditional negate: out = en ? ~in+1 : in).
  - Instanced for both operand magnitudes and the 2*WIDTH product fix-up (parameterised width).
  - Reusable by the divider.

Test Plan:
- Unsigned 7 x 6: hi=0, lo=0x0000002A.
  - done on cycle 32 (16 with SEQ_MUL_RADIX4_EN).
  - busy high for 32 cycles.
  - hi/lo unchanged until completion.
- Signed -3 x 5 (0xFFFFFFFD, 0x00000005): hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- 0xFFFFFFFF x 0xFFFFFFFF:
  - unsigned: hi=0xFFFFFFFE, lo=0x00000001.
  - signed: hi=0, lo=1.
- Signed 0x80000000 x 0x80000000: hi=0x40000000, lo=0. Signed 0x80000000 x 0: hi=lo=0.
- Restart at cycle 10 of 100 x 3 with 9 x 9:
  - exactly one done, 32 cycles after the second start.
  - result lo=81; 300 never appears on hi/lo.
- Reset pulsed low mid-RUN:
  - busy, done, hi and lo go to 0 immediately (asynchronously, before the next clock edge).
  - no done pulse follows.
  - the next start completes normally.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// rtl/seq_mul_pkg.sv - shared constants for the shift-add multiplier
package seq_mul_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH);
  localparam int ITERS_RADIX2  = DEFAULT_WIDTH;
  localparam int ITERS_RADIX4  = DEFAULT_WIDTH / 2;

  localparam logic SIGNED   = 1'b1;
  localparam logic UNSIGNED = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mul_state_e;

  function automatic int iters_radix2(input int width);
    return width;
  endfunction

  function automatic int iters_radix4(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/seq_mul_twos_abs.sv
// rtl/seq_mul_twos_abs.sv - conditional two's-complement negate, shared with the divider
module twos_abs #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] value,
  output logic [W-1:0] result
);

  assign result = en ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - iterative shift-add MULT/MULTU unit; SEQ_MUL_RADIX4_EN selects 2 bits/cycle
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sign_mode,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

`ifdef SEQ_MUL_RADIX4_EN
  localparam int SHIFT = 2;
  localparam int ITERS = iters_radix4(WIDTH);
`else
  localparam int SHIFT = 1;
  localparam int ITERS = iters_radix2(WIDTH);
`endif
  localparam int ACC_W = WIDTH + SHIFT;
  localparam int CW    = $clog2(WIDTH);

  mul_state_e           state_q, state_d;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH-1:0]     mcand_q, mplr_q;
  logic [ACC_W-1:0]     acc_q, addend, sum;
  logic [ACC_W+WIDTH-1:0] shifted;
  logic [2*WIDTH-1:0]   prod, prod_fix;
  logic [CW-1:0]        cnt_q;
  logic                 neg_q, signed_op, last;

  assign signed_op = (sign_mode == SIGNED);

  twos_abs #(.W(WIDTH)) u_abs_a (
    .en     (signed_op & multiplicand[WIDTH-1]),
    .value  (multiplicand),
    .result (mag_a)
  );

  twos_abs #(.W(WIDTH)) u_abs_b (
    .en     (signed_op & multiplier[WIDTH-1]),
    .value  (multiplier),
    .result (mag_b)
  );

  always_comb begin
    addend = '0;
`ifdef SEQ_MUL_RADIX4_EN
    if (mplr_q[0]) addend = addend + ACC_W'(mcand_q);
    if (mplr_q[1]) addend = addend + ACC_W'({mcand_q, 1'b0});
`else
    if (mplr_q[0]) addend = ACC_W'(mcand_q);
`endif
  end

  assign sum     = acc_q + addend;
  assign shifted = {sum, mplr_q} >> SHIFT;
  // Carry bits above 2*WIDTH are always zero on the final step and are dropped here.
  assign prod    = shifted[2*WIDTH-1:0];
  assign last    = (cnt_q == CW'(ITERS - 1));

  twos_abs #(.W(2 * WIDTH)) u_fix (
    .en     (neg_q),
    .value  (prod),
    .result (prod_fix)
  );

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else if (state_q == RUN && last) begin
      state_d = IDLE;
    end
  end

  assign busy = (state_q == RUN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else if (start) begin
      // A start mid-run simply reloads; the aborted result never reaches hi/lo.
      acc_q   <= '0;
      mcand_q <= mag_a;
      mplr_q  <= mag_b;
      cnt_q   <= '0;
      neg_q   <= signed_op & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == RUN) begin
        acc_q  <= shifted[ACC_W+WIDTH-1:WIDTH];
        mplr_q <= shifted[WIDTH-1:0];
        cnt_q  <= cnt_q + 1'b1;
        if (last) begin
          hi   <= prod_fix[2*WIDTH-1:WIDTH];
          lo   <= prod_fix[WIDTH-1:0];
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// tb/tb_seq_mul.sv - scoreboard bench for seq_mul
module tb_seq_mul;

  localparam int W = 32;
`ifdef SEQ_MUL_RADIX4_EN
  localparam int ITERS = 16;
`else
  localparam int ITERS = 32;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         sign_mode = 1'b0;
  logic [W-1:0] multiplicand = '0;
  logic [W-1:0] multiplier = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done;

  always #5 clock = ~clock;

  seq_mul #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .sign_mode    (sign_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   seen300 = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clock) begin
    exp_t e;
    if (lo === 32'd300 && hi === 32'd0) seen300++;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        e = sb.pop_front();
        check("result", {hi, lo}, {e.hi, e.lo});
        check("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input bit abort);
    exp_t e;
    @(negedge clock);
    multiplicand = a;
    multiplier   = b;
    sign_mode    = s;
    start        = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    if (abort && sb.size() != 0) void'(sb.pop_back());
    e.hi  = ehi;
    e.lo  = elo;
    e.cyc = cyc + ITERS;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL timeout: got busy=%0b pending=%0d expected idle", busy, sb.size());
    end
    @(negedge clock);
  endtask

  initial begin
    int busy_cycles;
    int hold_bad;
    int d0;

    #12;
    check("reset_state", {30'd0, busy, done, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // 7 x 6 unsigned with busy length and hold checks
    issue(32'd7, 32'd6, 1'b0, 32'h0, 32'h0000002A, 1'b0);
    busy_cycles = 0;
    hold_bad = 0;
    for (int i = 0; i < ITERS; i++) begin
      @(negedge clock);
      if (busy === 1'b1) busy_cycles++;
      if (hi !== 32'h0 || lo !== 32'h0) hold_bad++;
    end
    check("busy_cycles", 64'(busy_cycles), 64'(ITERS));
    check("hold_during_run", 64'(hold_bad), 64'd0);
    wait_idle();
    check("busy_after", {63'd0, busy}, 64'd0);

    issue(32'hFFFFFFFD, 32'h00000005, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    wait_idle();
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    wait_idle();
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001, 1'b0);
    wait_idle();
    issue(32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, 1'b0);
    wait_idle();
    issue(32'h80000000, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000, 1'b0);
    wait_idle();

    // restart 100 x 3 at cycle 10 with 9 x 9
    d0 = done_cnt;
    seen300 = 0;
    issue(32'd100, 32'd3, 1'b0, 32'h0, 32'd300, 1'b0);
    repeat (9) @(posedge clock);
    issue(32'd9, 32'd9, 1'b0, 32'h0, 32'd81, 1'b1);
    wait_idle();
    check("restart_done_count", 64'(done_cnt - d0), 64'd1);
    check("restart_no_300", 64'(seen300), 64'd0);

    // asynchronous reset mid-run
    issue(32'd1234, 32'd2, 1'b0, 32'h0, 32'd2468, 1'b0);
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset", {30'd0, busy, done, hi}, 64'd0);
    check("async_reset_lo", {32'd0, lo}, 64'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    d0 = done_cnt;
    repeat (ITERS + 4) @(negedge clock);
    check("no_done_after_reset", 64'(done_cnt - d0), 64'd0);

    issue(32'd12, 32'hFFFFFFF4, 1'b1, 32'hFFFFFFFF, 32'hFFFFFF70, 1'b0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
